// File: rtl/palette_pkg.sv
// Shared types and the boot colour table for the double-buffered palette.
// Both banks are loaded from DEFAULT_PALETTE after every reset.
package palette_pkg;

    localparam int PAL_IDX_W   = 4;
    localparam int PAL_ENTRIES = 2 ** PAL_IDX_W;
    localparam int PAL_COLOR_W = 12;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        COPY
    } pal_state_t;

    typedef logic [11:0] rgb12_t;

    // Classic 16-colour text-mode palette, packed {r,g,b} at 4 bits each
    localparam rgb12_t DEFAULT_PALETTE [PAL_ENTRIES] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/palette_bank.sv
// One palette bank: flop array with a single synchronous write port and two
// asynchronous read ports (pixel lookup and bank-to-bank copy).
module palette_bank
    import palette_pkg::*;
#(
    parameter int IDX_W   = PAL_IDX_W,
    parameter int COLOR_W = PAL_COLOR_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr_a,
    output logic [COLOR_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]   raddr_b,
    output logic [COLOR_W-1:0] rdata_b
);

    localparam int ENTRIES = 2 ** IDX_W;

    // Contents are not reset: the controller reloads every entry after reset
    logic [COLOR_W-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/palette_ctrl.sv
// Double-buffered 16-entry RGB palette: bus writes edit the shadow bank, and a
// committed edit becomes visible only at the next frame_start.
module palette_ctrl
    import palette_pkg::*;
#(
    parameter int IDX_W   = PAL_IDX_W,
    parameter int COLOR_W = PAL_COLOR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COLOR_W-1:0] wr_rgb,
    input  logic               commit_req,
    output logic               commit_pending,
    input  logic               frame_start,
    input  logic               pix_valid_in,
    input  logic [IDX_W-1:0]   pix_idx,
    output logic               pix_valid_out,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               init_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    pal_state_t         state;
    pal_state_t         state_next;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   cnt_next;
    logic               active_bank;
    logic               swap;

    logic               we0;
    logic               we1;
    logic [IDX_W-1:0]   bank_waddr;
    logic [COLOR_W-1:0] bank_wdata;

    logic [COLOR_W-1:0] pix_rd0;
    logic [COLOR_W-1:0] pix_rd1;
    logic [COLOR_W-1:0] copy_rd0;
    logic [COLOR_W-1:0] copy_rd1;
    logic [COLOR_W-1:0] pix_rd;
    logic [COLOR_W-1:0] copy_rd;

    logic [COLOR_W-1:0] rgb_p1;
    logic               vld_p1;

    palette_bank #(
        .IDX_W   (IDX_W),
        .COLOR_W (COLOR_W)
    ) bank0 (
        .clk     (clk),
        .we      (we0),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .raddr_a (pix_idx),
        .rdata_a (pix_rd0),
        .raddr_b (cnt),
        .rdata_b (copy_rd0)
    );

    palette_bank #(
        .IDX_W   (IDX_W),
        .COLOR_W (COLOR_W)
    ) bank1 (
        .clk     (clk),
        .we      (we1),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .raddr_a (pix_idx),
        .rdata_a (pix_rd1),
        .raddr_b (cnt),
        .rdata_b (copy_rd1)
    );

    assign pix_rd  = active_bank ? pix_rd1  : pix_rd0;
    assign copy_rd = active_bank ? copy_rd1 : copy_rd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Shadow bank is always the one not selected by active_bank
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_ready   = 1'b0;
        swap       = 1'b0;
        we0        = 1'b0;
        we1        = 1'b0;
        bank_waddr = cnt;
        bank_wdata = copy_rd;
        case (state)
            INIT: begin
                we0        = 1'b1;
                we1        = 1'b1;
                bank_wdata = COLOR_W'(DEFAULT_PALETTE[cnt]);
                cnt_next   = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                wr_ready = 1'b1;
                swap     = frame_start && (commit_pending || commit_req);
                if (wr_valid) begin
                    bank_waddr = wr_idx;
                    bank_wdata = wr_rgb;
                    we0        = active_bank;
                    we1        = ~active_bank;
                end
                if (swap) begin
                    state_next = COPY;
                    cnt_next   = '0;
                end
            end
            COPY: begin
                we0      = active_bank;
                we1      = ~active_bank;
                cnt_next = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            active_bank    <= 1'b0;
            commit_pending <= 1'b0;
            init_done      <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (swap) begin
                active_bank    <= ~active_bank;
                commit_pending <= 1'b0;
            end else if (commit_req) begin
                commit_pending <= 1'b1;
            end
            if (state == INIT && cnt == LAST_IDX) begin
                init_done <= 1'b1;
            end
        end
    end

    // Output stage p1: lookup uses the bank that is active before this edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            rgb_p1 <= '0;
        end else begin
            vld_p1 <= pix_valid_in;
            rgb_p1 <= pix_valid_in ? pix_rd : '0;
        end
    end

    assign pix_valid_out      = vld_p1;
    assign {red, green, blue} = rgb_p1;

endmodule

// File: tb/tb_palette_ctrl.sv
// Bench for palette_ctrl: directed table and corner sequences, then randomized
// traffic compared against a bank-level reference model.
module tb_palette_ctrl;
    import palette_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_idx;
    logic [11:0] wr_rgb;
    logic        commit_req;
    logic        commit_pending;
    logic        frame_start;
    logic        pix_valid_in;
    logic [3:0]  pix_idx;
    logic        pix_valid_out;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    palette_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_idx         (wr_idx),
        .wr_rgb         (wr_rgb),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .frame_start    (frame_start),
        .pix_valid_in   (pix_valid_in),
        .pix_idx        (pix_idx),
        .pix_valid_out  (pix_valid_out),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .init_done      (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic [3:0]  idx;
        logic        exp_v;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [11:0] rgb_now();
        return {red, green, blue};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid     = 1'b0;
        commit_req   = 1'b0;
        frame_start  = 1'b0;
        pix_valid_in = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!wr_ready && n < budget) begin
            tick();
            n++;
        end
        check("wait_ready", wr_ready, 1);
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [11:0] rgb);
        wait_ready(40);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_rgb   = rgb;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] idx, input logic [11:0] exp);
        pix_valid_in = 1'b1;
        pix_idx      = idx;
        tick();
        pix_valid_in = 1'b0;
        check(name, rgb_now(), exp);
    endtask

    task automatic commit_swap();
        wait_ready(40);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("commit_pending_set", commit_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("swap_clears_pending", commit_pending, 0);
        check("swap_enters_copy", wr_ready, 0);
    endtask

    // Reference model state: displayed palette, edited palette, stall cycles left
    logic [11:0] shown [16];
    logic [11:0] edit  [16];
    int          busy;
    bit          pending;

    initial begin
        int          stall;
        logic        exp_v;
        logic [11:0] exp_rgb;
        bit          accept;
        bit          do_swap;

        idle_inputs();
        wr_idx  = '0;
        wr_rgb  = '0;
        pix_idx = '0;

        // Reset state
        #3;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_pix_valid", pix_valid_out, 0);
        check("rst_rgb", rgb_now(), 0);
        check("rst_pending", commit_pending, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Default load takes exactly 16 cycles
        repeat (15) tick();
        check("init_done_c15", init_done, 0);
        check("wr_ready_c15", wr_ready, 0);
        tick();
        check("init_done_c16", init_done, 1);
        check("wr_ready_c16", wr_ready, 1);

        vecs[0] = '{1'b1, 4'd2,  1'b1, DEFAULT_PALETTE[2]};
        vecs[1] = '{1'b1, 4'd0,  1'b1, DEFAULT_PALETTE[0]};
        vecs[2] = '{1'b1, 4'd15, 1'b1, DEFAULT_PALETTE[15]};
        vecs[3] = '{1'b0, 4'd7,  1'b0, 12'h000};
        vecs[4] = '{1'b1, 4'd9,  1'b1, DEFAULT_PALETTE[9]};
        vecs[5] = '{1'b1, 4'd5,  1'b1, DEFAULT_PALETTE[5]};
        for (int i = 0; i < 6; i++) begin
            pix_valid_in = vecs[i].v;
            pix_idx      = vecs[i].idx;
            tick();
            check($sformatf("vec%0d_valid", i), pix_valid_out, vecs[i].exp_v);
            check($sformatf("vec%0d_rgb", i), rgb_now(), vecs[i].exp_rgb);
        end
        pix_valid_in = 1'b0;

        // Write without commit stays invisible
        write_entry(4'd5, 12'hF00);
        read_check("idx5_before_commit", 4'd5, DEFAULT_PALETTE[5]);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("pending_after_req", commit_pending, 1);

        // Pixel at the swap edge sees the old bank
        frame_start  = 1'b1;
        pix_valid_in = 1'b1;
        pix_idx      = 4'd5;
        tick();
        frame_start = 1'b0;
        check("swap_edge_old_bank", rgb_now(), DEFAULT_PALETTE[5]);
        check("swap_pending_clear", commit_pending, 0);

        // COPY stall: held write waits 16 cycles
        wr_valid = 1'b1;
        wr_idx   = 4'd3;
        wr_rgb   = 12'h0F0;
        stall    = 0;
        while (!wr_ready && stall < 40) begin
            tick();
            stall++;
            if (stall == 1) check("new_bank_idx5", rgb_now(), 12'hF00);
            pix_valid_in = 1'b0;
        end
        check("copy_stall_cycles", stall, 16);
        tick();
        wr_valid = 1'b0;
        read_check("idx3_not_yet_active", 4'd3, DEFAULT_PALETTE[3]);
        commit_swap();
        read_check("idx3_after_commit", 4'd3, 12'h0F0);
        read_check("idx5_kept_by_copy", 4'd5, 12'hF00);

        // Coincident write, commit and frame_start
        wait_ready(40);
        wr_valid    = 1'b1;
        wr_idx      = 4'd1;
        wr_rgb      = 12'hABC;
        commit_req  = 1'b1;
        frame_start = 1'b1;
        tick();
        idle_inputs();
        check("coinc_pending", commit_pending, 0);
        check("coinc_copy", wr_ready, 0);
        read_check("coinc_idx1", 4'd1, 12'hABC);
        read_check("coinc_idx3", 4'd3, 12'h0F0);

        // frame_start inside COPY is ignored, commit_req still latches
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("copy_fs_no_pending", commit_pending, 0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("copy_req_pending", commit_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("copy_fs_ignored", commit_pending, 1);
        check("copy_still_busy", wr_ready, 0);
        wait_ready(40);
        check("pending_into_run", commit_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("run_fs_swaps", commit_pending, 0);
        check("run_fs_copy", wr_ready, 0);

        // Async reset in the middle of COPY
        pix_valid_in = 1'b1;
        pix_idx      = 4'd1;
        tick();
        check("pre_reset_rgb", rgb_now(), 12'hABC);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("pre_reset_pending", commit_pending, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", pix_valid_out, 0);
        check("async_rst_rgb", rgb_now(), 0);
        check("async_rst_ready", wr_ready, 0);
        check("async_rst_init", init_done, 0);
        check("async_rst_pending", commit_pending, 0);
        @(posedge clk);
        #1;
        check("rst_held_valid", pix_valid_out, 0);
        reset_n      = 1'b1;
        pix_valid_in = 1'b0;

        // Events during INIT: commit latches, frame_start ignored
        tick();
        tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("init_fs_ignored", commit_pending, 1);
        read_check("init_partial_idx0", 4'd0, DEFAULT_PALETTE[0]);
        repeat (9) tick();
        check("reinit_c15", init_done, 0);
        tick();
        check("reinit_c16", init_done, 1);
        check("init_req_kept", commit_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("init_req_swaps", commit_pending, 0);
        check("init_req_copy", wr_ready, 0);
        for (int i = 0; i < 16; i++) begin
            read_check($sformatf("bank1_default%0d", i), 4'(i), DEFAULT_PALETTE[i]);
        end
        commit_swap();
        for (int i = 0; i < 16; i++) begin
            read_check($sformatf("bank0_default%0d", i), 4'(i), DEFAULT_PALETTE[i]);
        end

        // Randomized traffic against the reference model
        reset_n = 1'b0;
        idle_inputs();
        tick();
        reset_n = 1'b1;
        repeat (16) tick();
        for (int k = 0; k < 16; k++) begin
            shown[k] = DEFAULT_PALETTE[k];
            edit[k]  = DEFAULT_PALETTE[k];
        end
        busy    = 0;
        pending = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            wr_valid     = ($urandom % 3) == 0;
            wr_idx       = 4'($urandom);
            wr_rgb       = 12'($urandom);
            commit_req   = ($urandom % 16) == 0;
            frame_start  = ($urandom % 24) == 0;
            pix_valid_in = ($urandom % 4) != 0;
            pix_idx      = 4'($urandom);
            check("rnd_ready", wr_ready, busy == 0);
            check("rnd_pending", commit_pending, pending);
            exp_v   = pix_valid_in;
            exp_rgb = pix_valid_in ? shown[pix_idx] : 12'h000;
            accept  = wr_valid && busy == 0;
            do_swap = busy == 0 && frame_start && (pending || commit_req);
            if (accept) edit[wr_idx] = wr_rgb;
            if (do_swap) begin
                for (int k = 0; k < 16; k++) shown[k] = edit[k];
                busy    = 16;
                pending = 1'b0;
            end else begin
                if (commit_req) pending = 1'b1;
                if (busy > 0) busy--;
            end
            tick();
            check("rnd_pix_valid", pix_valid_out, exp_v);
            check("rnd_rgb", rgb_now(), exp_rgb);
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
